// File: rtl/cam_sccb_config_pkg.sv
// Shared types and constants for the OV7670 SCCB register sequencer.
// Covers the FSM state encoding, the ROM entry layout and the special register values.
package cam_sccb_config_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STRT,
      ST_BITS,
      ST_STOP,
      ST_WAIT,
      ST_DONE
   } state_t;

   localparam int ENTRY_W = 16;
   localparam int IDX_W   = 6;
   localparam int FRAME_W = 24;

   localparam logic [7:0]       END_MARK = 8'hFF;
   localparam logic [7:0]       REG_COM7 = 8'h12;
   localparam logic [IDX_W-1:0] IDX_LAST = 6'd63;
   localparam logic [4:0]       BIT_LAST = 5'd26;
   localparam logic [3:0]       ACK_POS  = 4'd8;

   typedef struct packed {
      logic [7:0] reg_addr;
      logic [7:0] val;
   } rom_entry_t;

   // Writing COM7 with bit7 set soft-resets the sensor, which needs a long settle time.
   function automatic logic needs_reset_wait(rom_entry_t e);
      return (e.reg_addr == REG_COM7) && e.val[7];
   endfunction

endpackage

// File: rtl/cam_sccb_config_if.sv
// Control and SCCB pin bundle of the camera configuration sequencer.
// master = the sequencer, slave = the surrounding top level.
interface cam_sccb_config_if;

   logic                                  start;
   logic                                  sioc;
   logic                                  siod_o;
   logic                                  siod_oe;
   logic                                  busy;
   logic                                  ready;
   logic [cam_sccb_config_pkg::IDX_W-1:0] idx;

   modport master (
      input  start,
      output sioc, siod_o, siod_oe, busy, ready, idx
   );

   modport slave (
      output start,
      input  sioc, siod_o, siod_oe, busy, ready, idx
   );

endinterface

// File: rtl/cam_sccb_config_rom.sv
// OV7670 register table (QVGA, RGB444) as a combinational {reg,val} lookup.
// OVERRIDE replaces it with a terminator-free fill pattern for exercising the index limit.
module cam_sccb_config_rom
   import cam_sccb_config_pkg::*;
#(
   parameter bit OVERRIDE = 1'b0
) (
   input  logic [IDX_W-1:0]   addr,
   output logic [ENTRY_W-1:0] entry
);

   always_comb begin
      // NOTE: default assignment first keeps this combinational block latch-free.
      entry = {END_MARK, END_MARK};
      if (OVERRIDE) begin
         entry = {2'b01, addr, {2'b00, addr} ^ 8'hA5};
      end else begin
         case (addr)
            6'd0:    entry = 16'h1280;   // COM7 soft reset
            6'd1:    entry = 16'h1214;   // COM7 QVGA, RGB
            6'd2:    entry = 16'h1101;
            6'd3:    entry = 16'h8C02;   // RGB444 enable
            6'd4:    entry = 16'h0400;
            6'd5:    entry = 16'h40D0;
            6'd6:    entry = 16'h3A04;
            6'd7:    entry = 16'h1418;
            6'd8:    entry = 16'h4FB3;
            6'd9:    entry = 16'h50B3;
            6'd10:   entry = 16'h5100;
            6'd11:   entry = 16'h523D;
            6'd12:   entry = 16'h53A7;
            6'd13:   entry = 16'h54E4;
            6'd14:   entry = 16'h589E;
            6'd15:   entry = 16'h3DC0;
            6'd16:   entry = 16'h1714;   // window: HSTART/HSTOP/HREF
            6'd17:   entry = 16'h1802;
            6'd18:   entry = 16'h3280;
            6'd19:   entry = 16'h1903;   // window: VSTART/VSTOP/VREF
            6'd20:   entry = 16'h1A7B;
            6'd21:   entry = 16'h030A;
            6'd22:   entry = 16'h0C04;
            6'd23:   entry = 16'h3E19;
            6'd24:   entry = 16'h703A;
            6'd25:   entry = 16'h7135;
            6'd26:   entry = 16'h7211;
            6'd27:   entry = 16'h73F1;
            6'd28:   entry = 16'hA202;
            default: entry = {END_MARK, END_MARK};
         endcase
      end
   end

endmodule

// File: rtl/cam_sccb_config.sv
// Walks the register ROM and emits each {reg,val} as a 3-phase SCCB write to the camera.
// Holds the quarter-bit divider, the sequencing FSM, the 24-bit shifter and the idle counter.
module cam_sccb_config
   import cam_sccb_config_pkg::*;
#(
   parameter int         CLK_DIV      = 250,
   parameter logic [7:0] DEV_ADDR     = 8'h42,
   parameter int         RST_WAIT     = 100_000,
   parameter int         GAP          = 400,
   parameter bit         ROM_OVERRIDE = 1'b0
) (
   input logic               clk,
   input logic               rst,
   cam_sccb_config_if.master bus
);

   localparam int QW = $clog2(CLK_DIV + 1);
   localparam int WW = $clog2(((RST_WAIT > GAP) ? RST_WAIT : GAP) + 1);
   localparam logic [QW-1:0] Q_LAST   = QW'(CLK_DIV - 1);
   localparam logic [WW-1:0] RST_LAST = WW'(RST_WAIT - 1);
   localparam logic [WW-1:0] GAP_LAST = WW'(GAP - 1);

   state_t             state;
   logic [QW-1:0]      qcnt;
   logic [1:0]         quarter;
   logic [FRAME_W-1:0] shift;
   logic [4:0]         bit_cnt;
   logic [3:0]         pos;
   logic [WW-1:0]      wait_cnt;
   logic [WW-1:0]      wait_last;
   logic [IDX_W-1:0]   idx;
   logic               sioc, siod_o, siod_oe, busy, ready;

   logic [ENTRY_W-1:0] rom_word;
   rom_entry_t         entry;
   logic               qtick;
   logic [FRAME_W-1:0] shift_nxt;
   logic [3:0]         pos_nxt;

   cam_sccb_config_rom #(.OVERRIDE(ROM_OVERRIDE)) u_rom (
      .addr  (idx),
      .entry (rom_word)
   );

   assign entry = rom_word;
   assign qtick = (qcnt == Q_LAST);

   // The ack slot (position 8 of each byte) consumes a bit clock but no shifter data.
   always_comb begin
      shift_nxt = shift;
      pos_nxt   = pos + 4'd1;
      if (pos == ACK_POS) begin
         pos_nxt = '0;
      end else begin
         shift_nxt = {shift[FRAME_W-2:0], 1'b0};
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every branch below
   // reads the pre-edge register values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         qcnt      <= '0;
         quarter   <= '0;
         shift     <= '0;
         bit_cnt   <= '0;
         pos       <= '0;
         wait_cnt  <= '0;
         wait_last <= '0;
         idx       <= '0;
         sioc      <= 1'b1;
         siod_o    <= 1'b1;
         siod_oe   <= 1'b1;
         busy      <= 1'b0;
         ready     <= 1'b0;
      end else begin
         qcnt <= qtick ? '0 : qcnt + QW'(1);
         case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  state <= ST_LOAD;
                  idx   <= '0;
                  busy  <= 1'b1;
                  ready <= 1'b0;
               end
            end

            ST_LOAD: begin
               qcnt    <= '0;
               quarter <= '0;
               sioc    <= 1'b1;
               siod_o  <= 1'b1;
               siod_oe <= 1'b1;
               if (entry.reg_addr == END_MARK || idx == IDX_LAST) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  ready <= 1'b1;
               end else begin
                  state     <= ST_STRT;
                  shift     <= {DEV_ADDR, entry.reg_addr, entry.val};
                  bit_cnt   <= '0;
                  pos       <= '0;
                  wait_last <= needs_reset_wait(entry) ? RST_LAST : GAP_LAST;
               end
            end

            // Outputs of quarter 0 are set on entry; each qtick sets up the next quarter.
            ST_STRT: begin
               if (qtick) begin
                  quarter <= quarter + 2'd1;
                  case (quarter)
                     2'd0: siod_o <= 1'b0;
                     2'd1: ;
                     2'd2: sioc <= 1'b0;
                     default: begin
                        state   <= ST_BITS;
                        siod_o  <= shift[FRAME_W-1];
                        siod_oe <= 1'b1;
                     end
                  endcase
               end
            end

            ST_BITS: begin
               if (qtick) begin
                  quarter <= quarter + 2'd1;
                  case (quarter)
                     2'd0: sioc <= 1'b1;
                     2'd1: ;
                     2'd2: sioc <= 1'b0;
                     default: begin
                        shift   <= shift_nxt;
                        pos     <= pos_nxt;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == BIT_LAST) begin
                           state   <= ST_STOP;
                           siod_o  <= 1'b0;
                           siod_oe <= 1'b1;
                        end else begin
                           siod_o  <= (pos_nxt == ACK_POS) ? 1'b1 : shift_nxt[FRAME_W-1];
                           siod_oe <= (pos_nxt != ACK_POS);
                        end
                     end
                  endcase
               end
            end

            ST_STOP: begin
               if (qtick) begin
                  quarter <= quarter + 2'd1;
                  case (quarter)
                     2'd0: sioc <= 1'b1;
                     2'd1: siod_o <= 1'b1;
                     2'd2: ;
                     default: begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                     end
                  endcase
               end
            end

            ST_WAIT: begin
               wait_cnt <= wait_cnt + WW'(1);
               if (wait_cnt == wait_last) begin
                  state <= ST_LOAD;
                  idx   <= idx + IDX_W'(1);
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.sioc    = sioc;
   assign bus.siod_o  = siod_o;
   assign bus.siod_oe = siod_oe;
   assign bus.busy    = busy;
   assign bus.ready   = ready;
   assign bus.idx     = idx;

endmodule

// File: tb/tb_cam_sccb_config.sv
// Scoreboard bench for cam_sccb_config: an SCCB monitor decodes writes and checks them
// against a queue of expected writes built from the register table.
module tb_cam_sccb_config;

   localparam int         CLK_DIV   = 4;
   localparam int         GAP       = 8;
   localparam int         RST_WAIT  = 64;
   localparam logic [7:0] DEV       = 8'h42;
   localparam int         WRITE_CYC = 116 * CLK_DIV + 1;

   typedef struct {
      logic [23:0] bytes;
      int          interval;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic rst_ovr;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   exp_t        exp_q[$];
   logic [15:0] rom_ref[$] = '{
      16'h1280, 16'h1214, 16'h1101, 16'h8C02, 16'h0400, 16'h40D0, 16'h3A04, 16'h1418,
      16'h4FB3, 16'h50B3, 16'h5100, 16'h523D, 16'h53A7, 16'h54E4, 16'h589E, 16'h3DC0,
      16'h1714, 16'h1802, 16'h3280, 16'h1903, 16'h1A7B, 16'h030A, 16'h0C04, 16'h3E19,
      16'h703A, 16'h7135, 16'h7211, 16'h73F1, 16'hA202, 16'hFFFF};
   int          n_entries;
   int          last_wait;
   logic [26:0] oe_exp;

   // Monitor state for the main DUT
   logic        p_sioc, p_siod, in_frame;
   int          nbits;
   logic [23:0] data;
   logic [26:0] oe_v;
   int          last_start;

   // Start-condition counter for the override DUT
   logic op_sioc, op_siod;
   int   ovr_starts = 0;

   cam_sccb_config_if bus ();
   cam_sccb_config_if ovr ();

   cam_sccb_config #(.CLK_DIV(CLK_DIV), .DEV_ADDR(DEV), .RST_WAIT(RST_WAIT), .GAP(GAP),
                     .ROM_OVERRIDE(1'b0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   cam_sccb_config #(.CLK_DIV(CLK_DIV), .DEV_ADDR(DEV), .RST_WAIT(RST_WAIT), .GAP(GAP),
                     .ROM_OVERRIDE(1'b1)) dut_ovr (
      .clk (clk),
      .rst (rst_ovr),
      .bus (ovr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int wait_len(input logic [15:0] e);
      return (e[15:8] == 8'h12 && e[7]) ? RST_WAIT : GAP;
   endfunction

   // Expected writes for one full table run: entries up to the first FF, each preceded
   // (except the first) by one write period plus the idle time owed to the previous entry.
   task automatic push_run();
      for (int i = 0; i < rom_ref.size(); i++) begin
         exp_t e;
         if (rom_ref[i][15:8] == 8'hFF) break;
         e.bytes    = {DEV, rom_ref[i]};
         e.interval = (i == 0) ? 0 : WRITE_CYC + wait_len(rom_ref[i-1]);
         exp_q.push_back(e);
         last_wait = wait_len(rom_ref[i]);
         n_entries = i + 1;
      end
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      logic found = 1'b0;
      int   seen_at = 0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (bus.ready) begin
            found   = 1'b1;
            seen_at = cyc;
            break;
         end
      end
      check({tag, "_ready_seen"}, found, 1);
      check({tag, "_ready_delay"}, seen_at - last_start, 1 + 115 * CLK_DIV + last_wait);
      check({tag, "_done_idx"}, bus.idx, n_entries);
      check({tag, "_done_busy"}, bus.busy, 0);
      check({tag, "_writes_left"}, exp_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sioc"}, bus.sioc, 1);
      check({tag, "_siod_o"}, bus.siod_o, 1);
      check({tag, "_siod_oe"}, bus.siod_oe, 1);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_ready"}, bus.ready, 0);
      check({tag, "_idx"}, bus.idx, 0);
   endtask

   // SCCB monitor: START/STOP are siod edges with sioc high; bits are taken on sioc rise.
   always @(negedge clk) begin
      if (rst) begin
         in_frame = 1'b0;
         nbits    = 0;
         p_sioc   = 1'b1;
         p_siod   = 1'b1;
      end else begin
         if (p_sioc && bus.sioc && p_siod && !bus.siod_o) begin
            check("start_outside_frame", in_frame, 0);
            check("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0 && exp_q[0].interval != 0)
               check("write_interval", cyc - last_start, exp_q[0].interval);
            in_frame   = 1'b1;
            nbits      = 0;
            data       = '0;
            oe_v       = '0;
            last_start = cyc;
         end else if (p_sioc && bus.sioc && !p_siod && bus.siod_o && in_frame) begin
            exp_t e;
            in_frame = 1'b0;
            // 27 bit clocks plus the clock pulse inside the STOP sequence
            check("sioc_rises", nbits, 28);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("write_bytes", data, e.bytes);
               check("ack_release", oe_v, oe_exp);
            end
         end
         if (!p_sioc && bus.sioc && in_frame) begin
            if (nbits < 27) begin
               oe_v[nbits] = bus.siod_oe;
               if (nbits % 9 != 8) data = {data[22:0], bus.siod_o};
            end
            nbits++;
         end
         p_sioc = bus.sioc;
         p_siod = bus.siod_o;
      end
   end

   always @(negedge clk) begin
      if (rst_ovr) begin
         op_sioc = 1'b1;
         op_siod = 1'b1;
      end else begin
         if (op_sioc && ovr.sioc && op_siod && !ovr.siod_o) ovr_starts++;
         op_sioc = ovr.sioc;
         op_siod = ovr.siod_o;
      end
   end

   initial begin
      logic found;
      rst       = 1'b1;
      rst_ovr   = 1'b1;
      bus.start = 1'b0;
      ovr.start = 1'b0;
      for (int i = 0; i < 27; i++) oe_exp[i] = (i % 9 != 8);

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst     = 1'b0;
      rst_ovr = 1'b0;
      @(negedge clk);

      ovr.start = 1'b1;
      @(negedge clk);
      ovr.start = 1'b0;

      // Run A: full table, with a stray start during bit 5 of the second write
      push_run();
      pulse_start();
      check("run_a_busy", bus.busy, 1);
      found = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (bus.idx == 1 && in_frame && nbits == 5) begin
            found = 1'b1;
            break;
         end
      end
      check("stray_window_reached", found, 1);
      pulse_start();
      check("stray_idx", bus.idx, 1);
      check("stray_busy", bus.busy, 1);
      wait_done("run_a");

      // Run B: restart from DONE repeats the whole table
      push_run();
      pulse_start();
      check("rerun_ready_drop", bus.ready, 0);
      check("rerun_busy", bus.busy, 1);
      wait_done("run_b");

      // Run C: reset in the middle of the register byte, then restart from index 0
      push_run();
      pulse_start();
      found = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (bus.idx == 0 && in_frame && nbits == 12) begin
            found = 1'b1;
            break;
         end
      end
      check("midreset_window_reached", found, 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs("midreset");
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_idle_busy", bus.busy, 0);
      push_run();
      pulse_start();
      wait_done("run_c");

      // Terminator-free ROM: must stop at index 63 after writing entries 0..62
      found = 1'b0;
      for (int i = 0; i < 40000; i++) begin
         if (ovr.ready) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("ovr_ready_seen", found, 1);
      check("ovr_write_count", ovr_starts, 63);
      check("ovr_idx", ovr.idx, 63);
      check("ovr_busy", ovr.busy, 0);
      repeat (600) @(negedge clk);
      check("ovr_no_extra_write", ovr_starts, 63);
      check("ovr_ready_held", ovr.ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
